riscv_trap_sequencer: RTL

//  Sequences the machine-mode trap response to misalignment and ECALL exceptions

---
 rtl/riscv_trap_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/riscv_trap_sequencer.sv
// Machine-mode trap sequencer: accepts a memory-stage exception or MRET, writes the trap CSRs,
// flushes the pipeline for a fixed number of cycles, then hands a redirect PC to fetch.
module riscv_trap_sequencer #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2  // legal range 1..15 (4-bit down-counter)
) (
  input  logic            i_riscv_trap_clk,
  input  logic            i_riscv_trap_rst,
  input  logic            i_riscv_trap_valid,
  input  logic            i_riscv_trap_inst_misalign,
  input  logic            i_riscv_trap_load_misalign,
  input  logic            i_riscv_trap_store_misalign,
  input  logic            i_riscv_trap_ecall,
  input  logic            i_riscv_trap_mret,
  input  logic [XLEN-1:0] i_riscv_trap_pc,
  input  logic [XLEN-1:0] i_riscv_trap_addr,
  input  logic [XLEN-1:0] i_riscv_trap_mtvec,
  input  logic [XLEN-1:0] i_riscv_trap_mepc,
  input  logic            i_riscv_trap_redirect_ready,
  output logic            o_riscv_trap_stall,
  output logic            o_riscv_trap_flush,
  output logic            o_riscv_trap_csr_we,
  output logic [XLEN-1:0] o_riscv_trap_mcause,
  output logic [XLEN-1:0] o_riscv_trap_mepc,
  output logic [XLEN-1:0] o_riscv_trap_mtval,
  output logic            o_riscv_trap_redirect_valid,
  output logic [XLEN-1:0] o_riscv_trap_redirect_pc
);

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StFlush,
    StRedirect
  } state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e          r_state;
  state_e          w_state_d;
  logic [3:0]      r_flush_cnt;
  logic [3:0]      w_flush_cnt_d;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_target;

  logic            w_idle;
  logic            w_misalign;
  logic            w_exc;
  logic            w_accept_exc;
  logic            w_accept_mret;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_mtval;
  logic [XLEN-1:0] w_exc_target;
  logic [XLEN-1:0] w_mret_target;

  // Event decode; flags only matter in IDLE with a valid memory-stage instruction.
  always_comb begin
    w_idle        = (r_state == StIdle);
    w_misalign    = i_riscv_trap_inst_misalign | i_riscv_trap_load_misalign |
                    i_riscv_trap_store_misalign;
    w_exc         = w_misalign | i_riscv_trap_ecall;
    w_accept_exc  = w_idle & i_riscv_trap_valid & w_exc;
    w_accept_mret = w_idle & i_riscv_trap_valid & i_riscv_trap_mret & ~w_exc;

    w_cause = XLEN'(11);
    if (i_riscv_trap_inst_misalign) begin
      w_cause = XLEN'(0);
    end else if (i_riscv_trap_load_misalign) begin
      w_cause = XLEN'(4);
    end else if (i_riscv_trap_store_misalign) begin
      w_cause = XLEN'(6);
    end

    w_mtval       = w_misalign ? i_riscv_trap_addr : '0;
    w_exc_target  = i_riscv_trap_mtvec & ~XLEN'(3);
    w_mret_target = i_riscv_trap_mepc & ~XLEN'(1);
  end

  always_comb begin
    w_state_d     = r_state;
    w_flush_cnt_d = r_flush_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept_exc) begin
          w_state_d = StCapture;
        end else if (w_accept_mret) begin
          w_state_d     = StFlush;
          w_flush_cnt_d = FlushLoad;
        end
      end
      StCapture: begin
        w_state_d     = StFlush;
        w_flush_cnt_d = FlushLoad;
      end
      StFlush: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_d = StRedirect;
        end else begin
          w_flush_cnt_d = r_flush_cnt - 4'd1;
        end
      end
      StRedirect: begin
        if (i_riscv_trap_redirect_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_riscv_trap_clk or posedge i_riscv_trap_rst) begin
    if (i_riscv_trap_rst) begin
      r_state     <= StIdle;
      r_flush_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_d;
      r_flush_cnt <= w_flush_cnt_d;
    end
  end

  // Cause/PC/tval hold until the next exception; MRET only replaces the redirect target.
  always_ff @(posedge i_riscv_trap_clk or posedge i_riscv_trap_rst) begin
    if (i_riscv_trap_rst) begin
      r_mcause <= '0;
      r_mepc   <= '0;
      r_mtval  <= '0;
      r_target <= '0;
    end else if (w_accept_exc) begin
      r_mcause <= w_cause;
      r_mepc   <= i_riscv_trap_pc;
      r_mtval  <= w_mtval;
      r_target <= w_exc_target;
    end else if (w_accept_mret) begin
      r_target <= w_mret_target;
    end
  end

  always_comb begin
    o_riscv_trap_stall          = ~w_idle | w_accept_exc | w_accept_mret;
    o_riscv_trap_flush          = (r_state == StFlush);
    o_riscv_trap_csr_we         = (r_state == StCapture);
    o_riscv_trap_redirect_valid = (r_state == StRedirect);
    o_riscv_trap_mcause         = r_mcause;
    o_riscv_trap_mepc           = r_mepc;
    o_riscv_trap_mtval          = r_mtval;
    o_riscv_trap_redirect_pc    = r_target;
  end

`ifndef SYNTHESIS
  a_csr_we_single: assert property (@(posedge i_riscv_trap_clk) disable iff (i_riscv_trap_rst)
    o_riscv_trap_csr_we |=> !o_riscv_trap_csr_we);

  a_redirect_hold: assert property (@(posedge i_riscv_trap_clk) disable iff (i_riscv_trap_rst)
    (o_riscv_trap_redirect_valid && !i_riscv_trap_redirect_ready) |=>
    (o_riscv_trap_redirect_valid && $stable(o_riscv_trap_redirect_pc)));
`endif

endmodule
